dest_reg_tracker: RTL

//  Tracks the destination-register tag of every in-flight instruction in EX, MEM and WB.

---
 rtl/fwd_pkg.sv | 25 ++
 rtl/dest_reg_tracker_if.sv | 33 +++
 rtl/fwd_slot_reg.sv | 28 ++
 rtl/dest_reg_tracker.sv | 85 ++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared forwarding types: register tag width, null tag and the per-stage slot record.
// Slots holding NULL_ADDR (R15 = PC) are never forwarded.
package fwd_pkg;

  localparam int AW = 4;
  localparam logic [AW-1:0] NULL_ADDR = 4'd15;

  typedef struct packed {
    logic          valid;
    logic          wb_en;
    logic          is_load;
    logic [AW-1:0] rd;
  } slot_t;

  localparam slot_t BUBBLE = '{valid: 1'b0, wb_en: 1'b0, is_load: 1'b0, rd: NULL_ADDR};

  function automatic logic fwd_ok(input slot_t s);
    return s.valid && s.wb_en && (s.rd != NULL_ADDR);
  endfunction

  function automatic logic [AW-1:0] fwd_tag(input slot_t s);
    return fwd_ok(s) ? s.rd : NULL_ADDR;
  endfunction

endpackage

// File: rtl/dest_reg_tracker_if.sv
// Bundle between the pipeline control and the destination-register tracker.
// master drives ID fields and hazard controls; slave (the tracker) returns tags and counters.
interface dest_reg_tracker_if #(parameter int CW = 16) ();

  logic                   id_valid;
  logic                   id_wb_en;
  logic [fwd_pkg::AW-1:0] id_rd;
  logic                   id_is_load;
  logic                   stall;
  logic                   flush;
  logic                   clr_cnt;

  logic [fwd_pkg::AW-1:0] m_add1;
  logic [fwd_pkg::AW-1:0] m_add2;
  logic [fwd_pkg::AW-1:0] m_add3;
  logic                   load;
  logic                   ex_valid;
  logic                   mem_valid;
  logic                   wb_valid;
  logic [CW-1:0]          stall_cnt;
  logic [CW-1:0]          flush_cnt;

  modport master (
    output id_valid, id_wb_en, id_rd, id_is_load, stall, flush, clr_cnt,
    input  m_add1, m_add2, m_add3, load, ex_valid, mem_valid, wb_valid, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_wb_en, id_rd, id_is_load, stall, flush, clr_cnt,
    output m_add1, m_add2, m_add3, load, ex_valid, mem_valid, wb_valid, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/fwd_slot_reg.sv
// One pipeline slot register; bubble insert overrides load, reset leaves a bubble.
// Latency 1 cycle; no backpressure of its own.
module fwd_slot_reg
  import fwd_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  i_en,
  input  logic  i_bubble,
  input  slot_t i_slot,
  output slot_t o_slot
);

  slot_t r_slot;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_slot <= BUBBLE;
    end else if (i_bubble) begin
      r_slot <= BUBBLE;
    end else if (i_en) begin
      r_slot <= i_slot;
    end
  end

  assign o_slot = r_slot;

endmodule

// File: rtl/dest_reg_tracker.sv
// Tracks EX/MEM/WB destination tags for forwarding, inserts bubbles on stall/flush,
// and keeps saturating stall/flush cycle counters. All outputs derive only from flops.
module dest_reg_tracker
  import fwd_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  dest_reg_tracker_if.slave bus
);

  slot_t w_id_slot;
  slot_t w_ex_slot;
  slot_t w_mem_slot;
  slot_t w_wb_slot;
  logic  w_ex_bubble;

  logic [CW-1:0] r_stall_cnt;
  logic [CW-1:0] r_flush_cnt;

  assign w_id_slot = '{valid: bus.id_valid, wb_en: bus.id_wb_en,
                       is_load: bus.id_is_load, rd: bus.id_rd};

  // Flush and stall both collapse to a single bubble; the stalled ID instruction is held upstream.
  assign w_ex_bubble = bus.flush | bus.stall | ~bus.id_valid;

  fwd_slot_reg u_ex (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_en     (1'b1),
    .i_bubble (w_ex_bubble),
    .i_slot   (w_id_slot),
    .o_slot   (w_ex_slot)
  );

  fwd_slot_reg u_mem (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_en     (1'b1),
    .i_bubble (1'b0),
    .i_slot   (w_ex_slot),
    .o_slot   (w_mem_slot)
  );

  fwd_slot_reg u_wb (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_en     (1'b1),
    .i_bubble (1'b0),
    .i_slot   (w_mem_slot),
    .o_slot   (w_wb_slot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (bus.clr_cnt) begin
      r_stall_cnt <= '0;
    end else if (bus.stall && !bus.flush && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_cnt <= '0;
    end else if (bus.clr_cnt) begin
      r_flush_cnt <= '0;
    end else if (bus.flush && (r_flush_cnt != '1)) begin
      r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign bus.m_add1    = fwd_tag(w_ex_slot);
  assign bus.m_add2    = fwd_tag(w_mem_slot);
  assign bus.m_add3    = fwd_tag(w_wb_slot);
  assign bus.load      = fwd_ok(w_ex_slot) & w_ex_slot.is_load;
  assign bus.ex_valid  = w_ex_slot.valid;
  assign bus.mem_valid = w_mem_slot.valid;
  assign bus.wb_valid  = w_wb_slot.valid;
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;

endmodule
